// File: rtl/frame_port_arbiter.sv
// Round-robin arbiter that gives one downstream frame consumer a single virtual
// header/body FIFO pair. A grant stays locked from selection until the consumer pops the header.
module frame_port_arbiter #(
  parameter int N_PORTS       = 4,
  parameter int GRANT_W       = 2,
  parameter int HEADER_DWIDTH = 128,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [N_PORTS*HEADER_DWIDTH-1:0] h_fifo_dout_in,
  input  logic [N_PORTS-1:0]               h_fifo_empty_in,
  output logic [N_PORTS-1:0]               h_fifo_rden_in,
  input  logic [N_PORTS*8-1:0]             b_fifo_dout_in,
  input  logic [N_PORTS-1:0]               b_fifo_empty_in,
  input  logic [N_PORTS-1:0]               b_fifo_del_in,
  output logic [N_PORTS-1:0]               b_fifo_rden_in,
  output logic [HEADER_DWIDTH-1:0]         h_fifo_dout,
  output logic                             h_fifo_empty,
  input  logic                             h_fifo_rden,
  output logic [7:0]                       b_fifo_dout,
  output logic                             b_fifo_empty,
  output logic                             b_fifo_del,
  input  logic                             b_fifo_rden,
  input  logic [N_PORTS-1:0]               port_en,
  output logic                             grant_valid,
  output logic [GRANT_W-1:0]               grant_idx,
  input  logic                             cnt_clr,
  output logic [N_PORTS*CNT_WIDTH-1:0]     frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_grant_valid;
  logic                 w_grant_valid_nxt;
  logic [GRANT_W-1:0]   r_grant_idx;
  logic [GRANT_W-1:0]   w_grant_idx_nxt;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [GRANT_W-1:0]   w_last_grant_nxt;
  logic [CNT_WIDTH-1:0] r_frame_cnt [N_PORTS];
  logic [N_PORTS-1:0]   w_req;
  logic                 w_pick_found;
  logic [GRANT_W-1:0]   w_pick_idx;
  logic                 w_locked;
  logic                 w_frame_end;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_req       = ~h_fifo_empty_in & port_en;
  assign w_locked    = (r_state == S_LOCK);
  assign w_frame_end = w_locked & h_fifo_rden & ~h_fifo_empty;
  assign grant_valid = r_grant_valid & w_locked;
  assign grant_idx   = r_grant_idx;

  // Scan from the far end back toward last_grant+1 so the nearest requester is written last and wins.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (w_req[(int'(r_last_grant) + k) % N_PORTS]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = GRANT_W'((int'(r_last_grant) + k) % N_PORTS);
      end
    end
  end

  always_comb begin
    h_fifo_dout    = '0;
    h_fifo_empty   = 1'b1;
    b_fifo_dout    = '0;
    b_fifo_empty   = 1'b1;
    b_fifo_del     = 1'b0;
    h_fifo_rden_in = '0;
    b_fifo_rden_in = '0;
    if (w_locked) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (r_grant_idx == GRANT_W'(i)) begin
          h_fifo_dout       = h_fifo_dout_in[i*HEADER_DWIDTH +: HEADER_DWIDTH];
          h_fifo_empty      = h_fifo_empty_in[i];
          b_fifo_dout       = b_fifo_dout_in[i*8 +: 8];
          b_fifo_empty      = b_fifo_empty_in[i];
          b_fifo_del        = b_fifo_del_in[i];
          h_fifo_rden_in[i] = h_fifo_rden;
          b_fifo_rden_in[i] = b_fifo_rden;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_valid_nxt = r_grant_valid;
    w_grant_idx_nxt   = r_grant_idx;
    w_last_grant_nxt  = r_last_grant;
    case (r_state)
      S_IDLE: begin
        w_grant_valid_nxt = 1'b0;
        if (w_pick_found) begin
          w_grant_idx_nxt   = w_pick_idx;
          w_grant_valid_nxt = 1'b1;
          w_state_nxt       = S_LOCK;
        end
      end
      S_LOCK: begin
        if (w_frame_end) begin
          w_last_grant_nxt  = r_grant_idx;
          w_grant_valid_nxt = 1'b0;
          w_state_nxt       = S_GAP;
        end
      end
      // One idle cycle lets the popped port's empty flag settle before rearbitration.
      S_GAP: begin
        w_grant_valid_nxt = 1'b0;
        w_state_nxt       = S_IDLE;
      end
      default: begin
        w_grant_valid_nxt = 1'b0;
        w_state_nxt       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= S_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_last_grant  <= GRANT_W'(N_PORTS - 1);
    end else begin
      r_state       <= w_state_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_last_grant  <= w_last_grant_nxt;
    end
  end

  // Clear beats a coincident increment.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_PORTS; i++) r_frame_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (cnt_clr)
          r_frame_cnt[i] <= '0;
        else if (w_frame_end && (r_grant_idx == GRANT_W'(i)))
          r_frame_cnt[i] <= sat_inc(r_frame_cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
    assign frame_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_frame_cnt[g];
  end

endmodule

// File: tb/tb_frame_port_arbiter.sv
// Directed bench for frame_port_arbiter: grant latency, round-robin order, port_en lock,
// ignored consumer pops outside a frame, counter saturation/clear and mid-frame reset.
module tb_frame_port_arbiter;
  localparam int NP = 4;
  localparam int GW = 2;
  localparam int HW = 128;
  localparam int CW = 8;  // narrow counter keeps saturation reachable in a short run

  logic              clk = 1'b0;
  logic              arst_n;
  logic [NP*HW-1:0]  h_fifo_dout_in;
  logic [NP-1:0]     h_fifo_empty_in;
  logic [NP-1:0]     h_fifo_rden_in;
  logic [NP*8-1:0]   b_fifo_dout_in;
  logic [NP-1:0]     b_fifo_empty_in;
  logic [NP-1:0]     b_fifo_del_in;
  logic [NP-1:0]     b_fifo_rden_in;
  logic [HW-1:0]     h_fifo_dout;
  logic              h_fifo_empty;
  logic              h_fifo_rden;
  logic [7:0]        b_fifo_dout;
  logic              b_fifo_empty;
  logic              b_fifo_del;
  logic              b_fifo_rden;
  logic [NP-1:0]     port_en;
  logic              grant_valid;
  logic [GW-1:0]     grant_idx;
  logic              cnt_clr;
  logic [NP*CW-1:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_port_arbiter #(
    .N_PORTS(NP), .GRANT_W(GW), .HEADER_DWIDTH(HW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .h_fifo_dout_in(h_fifo_dout_in), .h_fifo_empty_in(h_fifo_empty_in),
    .h_fifo_rden_in(h_fifo_rden_in),
    .b_fifo_dout_in(b_fifo_dout_in), .b_fifo_empty_in(b_fifo_empty_in),
    .b_fifo_del_in(b_fifo_del_in), .b_fifo_rden_in(b_fifo_rden_in),
    .h_fifo_dout(h_fifo_dout), .h_fifo_empty(h_fifo_empty), .h_fifo_rden(h_fifo_rden),
    .b_fifo_dout(b_fifo_dout), .b_fifo_empty(b_fifo_empty), .b_fifo_del(b_fifo_del),
    .b_fifo_rden(b_fifo_rden),
    .port_en(port_en), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .cnt_clr(cnt_clr), .frame_cnt(frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int p);
    return frame_cnt[p*CW +: CW];
  endfunction

  function automatic logic [HW-1:0] hdr_of(input int p);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(p);
    return {4{w}};
  endfunction

  task automatic do_reset();
    arst_n          = 1'b0;
    h_fifo_rden     = 1'b0;
    b_fifo_rden     = 1'b0;
    cnt_clr         = 1'b0;
    port_en         = '1;
    h_fifo_empty_in = '1;
    step();
    step();
    arst_n = 1'b1;
    step();
  endtask

  task automatic wait_grant(input string tag, input int exp_idx);
    for (int c = 0; c < 12; c++) begin
      if (grant_valid === 1'b1) break;
      step();
    end
    check_eq({tag, "_valid"}, grant_valid, 1'b1);
    check_eq({tag, "_idx"}, grant_idx, exp_idx);
  endtask

  task automatic run_frame(input string tag, input int exp_idx);
    wait_grant(tag, exp_idx);
    b_fifo_rden = 1'b1;
    #1;
    check_eq({tag, "_bdout"}, b_fifo_dout, 8'h10 + 8'(exp_idx));
    repeat (8) step();
    b_fifo_rden = 1'b0;
    h_fifo_rden = 1'b1;
    step();
    h_fifo_rden = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      h_fifo_dout_in[i*HW +: HW] = hdr_of(i);
      b_fifo_dout_in[i*8 +: 8]   = 8'h10 + 8'(i);
    end
    b_fifo_empty_in = '0;
    b_fifo_del_in   = '0;
    h_fifo_empty_in = '1;
    port_en         = '1;
    cnt_clr         = 1'b0;
    arst_n          = 1'b0;
    h_fifo_rden     = 1'b1;
    b_fifo_rden     = 1'b1;
    #12;
    // Reset state, with consumer pops held high to show they are not forwarded.
    check_eq("rst_gvalid", grant_valid, 1'b0);
    check_eq("rst_gidx", grant_idx, 2'd0);
    check_eq("rst_hempty", h_fifo_empty, 1'b1);
    check_eq("rst_bempty", b_fifo_empty, 1'b1);
    check_eq("rst_hdout", h_fifo_dout, 128'h0);
    check_eq("rst_bdout", b_fifo_dout, 8'h0);
    check_eq("rst_del", b_fifo_del, 1'b0);
    check_eq("rst_hrden", h_fifo_rden_in, 4'b0000);
    check_eq("rst_brden", b_fifo_rden_in, 4'b0000);
    check_eq("rst_cnt", frame_cnt, 32'h0);
    h_fifo_rden = 1'b0;
    b_fifo_rden = 1'b0;
    step();
    arst_n = 1'b1;
    step();

    // Single requester on port 2: one-cycle grant latency and mux/rden routing.
    h_fifo_empty_in = 4'b1011;
    b_fifo_del_in   = 4'b0100;
    #1;
    check_eq("p2_same_cycle", grant_valid, 1'b0);
    step();
    check_eq("p2_gvalid", grant_valid, 1'b1);
    check_eq("p2_gidx", grant_idx, 2'd2);
    check_eq("p2_hdout", h_fifo_dout, hdr_of(2));
    check_eq("p2_hempty", h_fifo_empty, 1'b0);
    check_eq("p2_bdout", b_fifo_dout, 8'h12);
    check_eq("p2_del", b_fifo_del, 1'b1);
    h_fifo_rden = 1'b1;
    b_fifo_rden = 1'b1;
    #1;
    check_eq("p2_hrden", h_fifo_rden_in, 4'b0100);
    check_eq("p2_brden", b_fifo_rden_in, 4'b0100);
    step();
    h_fifo_empty_in = '1;
    b_fifo_del_in   = '0;
    #1;
    check_eq("gap_gvalid", grant_valid, 1'b0);
    check_eq("gap_hrden", h_fifo_rden_in, 4'b0000);
    check_eq("gap_hempty", h_fifo_empty, 1'b1);
    check_eq("p2_cnt", cnt_of(2), 8'd1);
    step();
    check_eq("idle_hrden", h_fifo_rden_in, 4'b0000);
    check_eq("idle_brden", b_fifo_rden_in, 4'b0000);
    step();
    check_eq("idle_cnt2", cnt_of(2), 8'd1);
    check_eq("idle_cnt0", cnt_of(0), 8'd0);
    h_fifo_rden = 1'b0;
    b_fifo_rden = 1'b0;

    // All four ports requesting: grant order 0,1,2,3,0.
    do_reset();
    h_fifo_empty_in = '0;
    run_frame("rr0", 0);
    run_frame("rr1", 1);
    run_frame("rr2", 2);
    run_frame("rr3", 3);
    for (int p = 0; p < NP; p++) check_eq($sformatf("rr_cnt%0d", p), cnt_of(p), 8'd1);
    run_frame("rr4", 0);
    check_eq("rr_cnt0_b", cnt_of(0), 8'd2);

    // port_en dropped mid-frame: frame completes, port then stays unserved.
    do_reset();
    h_fifo_empty_in = 4'b1101;
    wait_grant("pe", 1);
    b_fifo_rden = 1'b1;
    repeat (3) step();
    port_en = 4'b1101;
    step();
    check_eq("pe_hold_valid", grant_valid, 1'b1);
    check_eq("pe_hold_idx", grant_idx, 2'd1);
    repeat (4) step();
    b_fifo_rden = 1'b0;
    h_fifo_rden = 1'b1;
    step();
    h_fifo_rden = 1'b0;
    check_eq("pe_cnt1", cnt_of(1), 8'd1);
    repeat (5) step();
    check_eq("pe_blocked", grant_valid, 1'b0);
    h_fifo_empty_in = 4'b0101;
    wait_grant("pe_next", 3);
    h_fifo_rden = 1'b1;
    step();
    h_fifo_rden = 1'b0;
    port_en = '1;

    // Saturation of port 0's counter, then clear coinciding with a frame end.
    do_reset();
    h_fifo_empty_in = 4'b1110;
    h_fifo_rden     = 1'b1;
    for (int c = 0; c < 1200 && cnt_of(0) !== 8'hFF; c++) step();
    check_eq("sat_reach", cnt_of(0), 8'hFF);
    repeat (6) step();
    check_eq("sat_hold", cnt_of(0), 8'hFF);
    h_fifo_rden = 1'b0;
    wait_grant("sat", 0);
    h_fifo_rden = 1'b1;
    cnt_clr     = 1'b1;
    step();
    h_fifo_rden = 1'b0;
    cnt_clr     = 1'b0;
    check_eq("clr_prio", cnt_of(0), 8'd0);

    // Asynchronous reset in the middle of a port 3 body.
    do_reset();
    h_fifo_empty_in = 4'b0111;
    wait_grant("mid", 3);
    b_fifo_rden = 1'b1;
    step();
    step();
    check_eq("mid_brden", b_fifo_rden_in, 4'b1000);
    arst_n = 1'b0;
    #1;
    check_eq("arst_brden", b_fifo_rden_in, 4'b0000);
    check_eq("arst_hempty", h_fifo_empty, 1'b1);
    check_eq("arst_bempty", b_fifo_empty, 1'b1);
    check_eq("arst_gvalid", grant_valid, 1'b0);
    check_eq("arst_gidx", grant_idx, 2'd0);
    b_fifo_rden = 1'b0;
    step();
    arst_n = 1'b1;
    h_fifo_empty_in = 4'b0110;
    wait_grant("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
